// File: rtl/wb_ram_slave_if.sv
// Wishbone B3 bus bundle between a master (CPU ICMU/DCMU port) and the RAM slave.
// Handshake: a beat is requested while cyc&stb=1 and completes on the rising edge where ack=1;
// the master holds addr/we/sel/data/cti/bte stable until that edge, and read data is valid only with ack.
interface wb_ram_slave_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic [31:2] wbs_addr_i;
    logic [2:0]  wbs_cti_i;
    logic [1:0]  wbs_bte_i;
    logic [3:0]  wbs_sel_i;
    logic        wbs_we_i;
    logic [31:0] wbs_data_i;
    logic [31:0] wbs_data_o;
    logic        wbs_ack_o;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_addr_i, wbs_cti_i, wbs_bte_i,
        input  wbs_sel_i, wbs_we_i, wbs_data_i,
        output wbs_data_o, wbs_ack_o
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_addr_i, wbs_cti_i, wbs_bte_i,
        output wbs_sel_i, wbs_we_i, wbs_data_i,
        input  wbs_data_o, wbs_ack_o
    );
endinterface

// File: rtl/wb_ram_slave.sv
// Wishbone B3 slave with single-port word RAM: classic cycles plus registered-feedback
// incrementing bursts (linear / wrap4 / wrap8 / wrap16) with an optional initial wait.
module wb_ram_slave #(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    wb_ram_slave_if.slave bus,
    output logic [1:0]    dbg_state
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SINGLE, S_BURST} state_t;

    localparam logic [2:0]           WAIT_LOAD = 3'(WAIT_CYCLES - 1);
    localparam logic [ADDR_BITS-1:0] ONE       = ADDR_BITS'(1);

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] a_q, a_d, a_inc, wrap_mask;
    logic [1:0]           bte_q, bte_d;
    logic                 burst_q, burst_d;
    logic [2:0]           wcnt_q, wcnt_d;
    logic                 req, ack;
    logic [31:0]          rd_q, last_q;
    logic [31:0]          mem [2**ADDR_BITS];
    logic                 unused_addr;

    assign req         = bus.wbs_cyc_i & bus.wbs_stb_i;
    assign unused_addr = ^bus.wbs_addr_i[31:ADDR_BITS+2];

    // Wrapping bursts only advance the low log2(N) bits; linear uses the whole counter.
    always_comb begin
        wrap_mask = '1;
        case (bte_q)
            2'b01:   wrap_mask = ADDR_BITS'(3);
            2'b10:   wrap_mask = ADDR_BITS'(7);
            2'b11:   wrap_mask = ADDR_BITS'(15);
            default: wrap_mask = '1;
        endcase
        a_inc = (a_q & ~wrap_mask) | ((a_q + ONE) & wrap_mask);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        bte_d   = bte_q;
        burst_d = burst_q;
        wcnt_d  = wcnt_q;
        ack     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    a_d     = bus.wbs_addr_i[ADDR_BITS+1:2];
                    bte_d   = bus.wbs_bte_i;
                    burst_d = (bus.wbs_cti_i == 3'b010);
                    if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        wcnt_d  = WAIT_LOAD;
                    end else begin
                        state_d = (bus.wbs_cti_i == 3'b010) ? S_BURST : S_SINGLE;
                    end
                end
            end
            S_WAIT: begin
                if (!bus.wbs_cyc_i)   state_d = S_IDLE;
                else if (wcnt_q == 3'd0) state_d = burst_q ? S_BURST : S_SINGLE;
                else                  wcnt_d  = wcnt_q - 3'd1;
            end
            S_SINGLE: begin
                if (!bus.wbs_cyc_i) begin
                    state_d = S_IDLE;
                end else if (bus.wbs_stb_i) begin
                    ack     = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_BURST: begin
                if (!bus.wbs_cyc_i) begin
                    state_d = S_IDLE;
                end else if (bus.wbs_stb_i) begin
                    ack = 1'b1;
                    a_d = a_inc;
                    if (bus.wbs_cti_i == 3'b111) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // rd_q always holds RAM at the address the next cycle will present, so bursts have no bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            bte_q   <= 2'b00;
            burst_q <= 1'b0;
            wcnt_q  <= 3'd0;
            rd_q    <= 32'd0;
            last_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            bte_q   <= bte_d;
            burst_q <= burst_d;
            wcnt_q  <= wcnt_d;
            rd_q    <= mem[a_d];
            if (ack) last_q <= rd_q;
        end
    end

    always_ff @(posedge clk) begin
        if (ack && bus.wbs_we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.wbs_sel_i[i]) mem[a_q][8*i +: 8] <= bus.wbs_data_i[8*i +: 8];
            end
        end
    end

    assign bus.wbs_ack_o  = ack;
    assign bus.wbs_data_o = ack ? rd_q : last_q;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_wb_ram_slave.sv
// Self-checking bench for wb_ram_slave: one instance with no wait states, one with WAIT_CYCLES=3.
module tb_wb_ram_slave;
  localparam int AB = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  logic [1:0] st0, st3;

  wb_ram_slave_if bus0();
  wb_ram_slave_if bus3();

  wb_ram_slave #(.ADDR_BITS(AB), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave), .dbg_state(st0)
  );
  wb_ram_slave #(.ADDR_BITS(AB), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3.slave), .dbg_state(st3)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic bus_idle();
    bus0.wbs_cyc_i = 0; bus0.wbs_stb_i = 0; bus0.wbs_addr_i = '0; bus0.wbs_cti_i = 0;
    bus0.wbs_bte_i = 0; bus0.wbs_sel_i = 0; bus0.wbs_we_i = 0; bus0.wbs_data_i = 0;
    bus3.wbs_cyc_i = 0; bus3.wbs_stb_i = 0; bus3.wbs_addr_i = '0; bus3.wbs_cti_i = 0;
    bus3.wbs_bte_i = 0; bus3.wbs_sel_i = 0; bus3.wbs_we_i = 0; bus3.wbs_data_i = 0;
  endtask

  // Classic cycle on dut0; reads pop their expected word from the scoreboard queue.
  task automatic wb_classic(input logic we, input logic [31:2] addr, input logic [31:0] data,
                            input logic [3:0] sel, input string name);
    int lat;
    bit got;
    logic [31:0] exp;
    @(posedge clk); #1;
    bus0.wbs_cyc_i = 1; bus0.wbs_stb_i = 1; bus0.wbs_we_i = we; bus0.wbs_addr_i = addr;
    bus0.wbs_data_i = data; bus0.wbs_sel_i = sel; bus0.wbs_cti_i = 3'b000; bus0.wbs_bte_i = 2'b00;
    lat = 0; got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus0.wbs_ack_o) begin got = 1; break; end
      lat++;
    end
    n_tests++;
    if (!got || lat != 1) begin
      n_fail++; $display("FAIL %s latency got=%0d (ack seen=%0d) exp=1", name, lat, got);
    end
    if (!we) begin
      exp = exp_q.pop_front();
      n_tests++;
      if (bus0.wbs_data_o !== exp) begin
        n_fail++; $display("FAIL %s data got=%h exp=%h", name, bus0.wbs_data_o, exp);
      end
    end
    @(posedge clk); #1;
    bus0.wbs_cyc_i = 0; bus0.wbs_stb_i = 0; bus0.wbs_we_i = 0;
    @(negedge clk);
    n_tests++;
    if (bus0.wbs_ack_o !== 1'b0) begin
      n_fail++; $display("FAIL %s ack_one_cycle got=%b exp=0", name, bus0.wbs_ack_o);
    end
  endtask

  task automatic test_reset();
    #2;
    n_tests++;
    if (bus0.wbs_ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack got=%b exp=0", bus0.wbs_ack_o); end
    n_tests++;
    if (bus0.wbs_data_o !== 32'd0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", bus0.wbs_data_o); end
    n_tests++;
    if (st0 !== 2'd0 || st3 !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d/%0d exp=0/0", st0, st3); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_classic();
    wb_classic(1, 30'h10, 32'hDEADBEEF, 4'hF, "classic_wr");
    exp_q.push_back(32'hDEADBEEF);
    wb_classic(0, 30'h10, 32'h0, 4'hF, "classic_rd");
  endtask

  task automatic test_byte_write();
    wb_classic(1, 30'h10, 32'h0000AB00, 4'b0010, "byte_wr");
    exp_q.push_back(32'hDEADABEF);
    wb_classic(0, 30'h10, 32'h0, 4'hF, "byte_rd");
    wb_classic(1, 30'h10, 32'hFFFFFFFF, 4'b0000, "sel0_wr");
    exp_q.push_back(32'hDEADABEF);
    wb_classic(0, 30'h10, 32'h0, 4'hF, "sel0_rd");
  endtask

  task automatic test_wrap4();
    int beats, first, cyc_cnt;
    logic [31:0] exp;
    for (int k = 4; k < 8; k++) wb_classic(1, 30'(k), 32'(k), 4'hF, "wrap_fill");
    exp_q.push_back(32'd6); exp_q.push_back(32'd7); exp_q.push_back(32'd4); exp_q.push_back(32'd5);
    @(posedge clk); #1;
    bus0.wbs_cyc_i = 1; bus0.wbs_stb_i = 1; bus0.wbs_we_i = 0; bus0.wbs_addr_i = 30'd6;
    bus0.wbs_cti_i = 3'b010; bus0.wbs_bte_i = 2'b01; bus0.wbs_sel_i = 4'hF;
    beats = 0; first = -1; cyc_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cyc_cnt++;
      if (bus0.wbs_ack_o) begin
        if (first < 0) first = cyc_cnt;
        exp = exp_q.pop_front();
        n_tests++;
        if (bus0.wbs_data_o !== exp) begin
          n_fail++; $display("FAIL wrap4_beat%0d got=%h exp=%h", beats, bus0.wbs_data_o, exp);
        end
        beats++;
      end
      @(posedge clk); #1;
      if (beats == 4) break;
      bus0.wbs_addr_i = 30'($urandom);
      if (beats == 3) bus0.wbs_cti_i = 3'b111;
    end
    bus0.wbs_cyc_i = 0; bus0.wbs_stb_i = 0; bus0.wbs_cti_i = 3'b000;
    n_tests++;
    if (beats != 4 || first != 2 || cyc_cnt - first != 3) begin
      n_fail++; $display("FAIL wrap4_timing beats=%0d first=%0d span=%0d exp 4/2/3", beats, first, cyc_cnt - first);
    end
    @(negedge clk);
    n_tests++;
    if (st0 !== 2'd0 || bus0.wbs_ack_o !== 1'b0) begin
      n_fail++; $display("FAIL wrap4_end state=%0d ack=%b exp 0/0", st0, bus0.wbs_ack_o);
    end
  endtask

  task automatic test_linear_gap();
    int b;
    bit gap;
    @(posedge clk); #1;
    bus0.wbs_cyc_i = 1; bus0.wbs_stb_i = 1; bus0.wbs_we_i = 1; bus0.wbs_addr_i = 30'd1022;
    bus0.wbs_cti_i = 3'b010; bus0.wbs_bte_i = 2'b00; bus0.wbs_sel_i = 4'hF;
    bus0.wbs_data_i = 32'hC0DE0000;
    b = 0; gap = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus0.wbs_stb_i && bus0.wbs_ack_o) b++;
      else if (!bus0.wbs_stb_i) begin
        n_tests++;
        if (bus0.wbs_ack_o !== 1'b0) begin n_fail++; $display("FAIL lin_gap_ack got=%b exp=0", bus0.wbs_ack_o); end
      end
      @(posedge clk); #1;
      if (b == 8) break;
      bus0.wbs_addr_i = 30'($urandom);
      bus0.wbs_data_i = 32'hC0DE0000 + 32'(b);
      bus0.wbs_cti_i = (b == 7) ? 3'b111 : 3'b010;
      if (b == 2 && !gap) begin bus0.wbs_stb_i = 0; gap = 1; end
      else bus0.wbs_stb_i = 1;
    end
    bus0.wbs_cyc_i = 0; bus0.wbs_stb_i = 0; bus0.wbs_we_i = 0; bus0.wbs_cti_i = 3'b000;
    n_tests++;
    if (b != 8 || !gap) begin n_fail++; $display("FAIL lin_beats got=%0d gap=%0d exp=8/1", b, gap); end
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(32'hC0DE0000 + 32'(k));
      wb_classic(0, 30'((1022 + k) % 1024), 32'h0, 4'hF, "lin_readback");
    end
  endtask

  task automatic test_wait();
    int lat;
    bit got, seen;
    for (int op = 0; op < 2; op++) begin
      @(posedge clk); #1;
      bus3.wbs_cyc_i = 1; bus3.wbs_stb_i = 1; bus3.wbs_we_i = (op == 0); bus3.wbs_addr_i = 30'd3;
      bus3.wbs_data_i = 32'h12345678; bus3.wbs_sel_i = 4'hF; bus3.wbs_cti_i = 3'b000;
      lat = 0; got = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (bus3.wbs_ack_o) begin got = 1; break; end
        lat++;
      end
      n_tests++;
      if (!got || lat != 4) begin n_fail++; $display("FAIL wait_latency op=%0d got=%0d exp=4", op, lat); end
      if (op == 1) begin
        n_tests++;
        if (bus3.wbs_data_o !== 32'h12345678) begin
          n_fail++; $display("FAIL wait_rd_data got=%h exp=12345678", bus3.wbs_data_o);
        end
      end
      @(posedge clk); #1;
      bus3.wbs_cyc_i = 0; bus3.wbs_stb_i = 0; bus3.wbs_we_i = 0;
    end
    @(posedge clk); #1;
    bus3.wbs_cyc_i = 1; bus3.wbs_stb_i = 1; bus3.wbs_addr_i = 30'd3;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (st3 !== 2'd1) begin n_fail++; $display("FAIL wait_state got=%0d exp=1", st3); end
    @(posedge clk); #1;
    bus3.wbs_cyc_i = 0; bus3.wbs_stb_i = 0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus3.wbs_ack_o) seen = 1;
    end
    n_tests++;
    if (seen || st3 !== 2'd0) begin n_fail++; $display("FAIL wait_abort ack_seen=%0d state=%0d exp 0/0", seen, st3); end
  endtask

  task automatic test_reset_mid_burst();
    int b;
    bit hit;
    for (int k = 0; k < 4; k++) wb_classic(1, 30'(100 + k), 32'hAAAA0000 + 32'(k), 4'hF, "rst_fill");
    @(posedge clk); #1;
    bus0.wbs_cyc_i = 1; bus0.wbs_stb_i = 1; bus0.wbs_we_i = 1; bus0.wbs_addr_i = 30'd100;
    bus0.wbs_cti_i = 3'b010; bus0.wbs_bte_i = 2'b00; bus0.wbs_sel_i = 4'hF;
    bus0.wbs_data_i = 32'hBBBB0000;
    b = 0; hit = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus0.wbs_ack_o) b++;
      if (b == 3) begin
        hit = 1;
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus0.wbs_ack_o !== 1'b0 || bus0.wbs_data_o !== 32'd0 || st0 !== 2'd0) begin
          n_fail++; $display("FAIL rst_async ack=%b data=%h state=%0d exp 0/0/0", bus0.wbs_ack_o, bus0.wbs_data_o, st0);
        end
        break;
      end
      @(posedge clk); #1;
      bus0.wbs_data_i = 32'hBBBB0000 + 32'(b);
    end
    n_tests++;
    if (!hit) begin n_fail++; $display("FAIL rst_burst_acks got=%0d exp=3", b); end
    @(posedge clk); #1;
    bus0.wbs_cyc_i = 0; bus0.wbs_stb_i = 0; bus0.wbs_we_i = 0; bus0.wbs_cti_i = 3'b000;
    @(negedge clk); rst_n = 1'b1;
    exp_q.push_back(32'hBBBB0000); wb_classic(0, 30'd100, 32'h0, 4'hF, "rst_rd100");
    exp_q.push_back(32'hBBBB0001); wb_classic(0, 30'd101, 32'h0, 4'hF, "rst_rd101");
    exp_q.push_back(32'hAAAA0002); wb_classic(0, 30'd102, 32'h0, 4'hF, "rst_rd102");
    exp_q.push_back(32'hAAAA0003); wb_classic(0, 30'd103, 32'h0, 4'hF, "rst_rd103");
  endtask

  initial begin
    bus_idle();
    test_reset();
    test_classic();
    test_byte_write();
    test_wrap4();
    test_linear_gap();
    test_wait();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
